// File: rtl/fp_pkg.sv
// fp_pkg
// Shared definitions for the sequential floating-point unit:
//   - opcode values presented on the op port
//   - FSM state encoding used by fp_seq_unit
//   - builders for the canonical quiet-NaN and infinity bit patterns at any
//     exponent/fraction width (callers slice the low 1+exp_w+man_w bits)
package fp_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_UNPACK  = 4'd1;
    localparam logic [3:0] S_SPECIAL = 4'd2;
    localparam logic [3:0] S_ALIGN   = 4'd3;
    localparam logic [3:0] S_ADD     = 4'd4;
    localparam logic [3:0] S_MUL     = 4'd5;
    localparam logic [3:0] S_NORM    = 4'd6;
    localparam logic [3:0] S_ROUND   = 4'd7;
    localparam logic [3:0] S_DONE    = 4'd8;

    // Widest packed format the builders can describe.
    localparam int FP_MAX_W = 128;

    // Quiet NaN: sign 0, exponent all ones, fraction MSB set, rest clear.
    function automatic logic [FP_MAX_W-1:0] fp_qnan(input int exp_w, input int man_w);
        logic [FP_MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < FP_MAX_W; i++) begin
            if (i >= man_w - 1 && i < man_w + exp_w)
                v[i] = 1'b1;
        end
        return v;
    endfunction

    // Infinity: exponent all ones, fraction zero, caller-chosen sign.
    function automatic logic [FP_MAX_W-1:0] fp_inf(input logic sign, input int exp_w, input int man_w);
        logic [FP_MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < FP_MAX_W; i++) begin
            if (i >= man_w && i < man_w + exp_w)
                v[i] = 1'b1;
            else if (i == man_w + exp_w)
                v[i] = sign;
        end
        return v;
    endfunction

endpackage

// File: rtl/fp_round.sv
// fp_round
// Combinational round-to-nearest-even and packing stage.
// Ports:
//   sign    in   result sign
//   exp_in  in   biased exponent, signed EXP_W+2 bits (may be out of range)
//   mant    in   normalised significand {hidden, frac, G, R, S}
//   result  out  packed {sign, exp, frac}
//   ovf     out  exponent overflowed to infinity
//   unf     out  exponent underflowed, result flushed to zero
//   inx     out  result is not exact
module fp_round
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                     sign,
    input  logic signed [EXP_W+1:0]  exp_in,
    input  logic [MAN_W+3:0]         mant,
    output logic [EXP_W+MAN_W:0]     result,
    output logic                     ovf,
    output logic                     unf,
    output logic                     inx
);

    localparam int W = 1 + EXP_W + MAN_W;
    localparam logic [FP_MAX_W-1:0] INF_FULL = fp_inf(1'b0, EXP_W, MAN_W);
    localparam logic [W-2:0] INF_MAG = INF_FULL[W-2:0];
    localparam logic signed [EXP_W+1:0] EXP_ALL_ONES = {2'b00, {EXP_W{1'b1}}};

    logic                    lsb;
    logic                    g;
    logic                    rb;
    logic                    s;
    logic                    round_up;
    logic [MAN_W+1:0]        sig;
    logic signed [EXP_W+1:0] exp_fin;

    // A carry out of the rounded significand leaves it as 10...0, so the
    // fraction bits are already zero and only the exponent needs bumping.
    always_comb begin
        lsb      = mant[3];
        g        = mant[2];
        rb       = mant[1];
        s        = mant[0];
        round_up = g & (rb | s | lsb);
        sig      = {1'b0, mant[MAN_W+3:3]} + {{(MAN_W+1){1'b0}}, round_up};
        exp_fin  = exp_in + {{(EXP_W+1){1'b0}}, sig[MAN_W+1]};

        result = {sign, exp_fin[EXP_W-1:0], sig[MAN_W-1:0]};
        ovf    = 1'b0;
        unf    = 1'b0;
        inx    = g | rb | s;

        if (exp_fin >= EXP_ALL_ONES) begin
            result = {sign, INF_MAG};
            ovf    = 1'b1;
            inx    = 1'b1;
        end else if (exp_fin[EXP_W+1] || exp_fin == '0) begin
            result = {sign, {(W-1){1'b0}}};
            unf    = 1'b1;
            inx    = 1'b1;
        end
    end

endmodule

// File: rtl/fp_seq_unit.sv
// fp_seq_unit
// Multi-cycle floating-point add / subtract / multiply with round-to-nearest-
// even, zero/inf/NaN handling and status flags. One operation at a time.
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset
//   a, b   in   operands {sign, exp, frac}
//   op     in   00 add, 01 sub (a-b), 10 mul, 11 behaves as add
//   start  in   request, only looked at while idle
//   busy   out  operation in progress
//   done   out  one-cycle pulse when r and flags are fresh
//   r      out  result, held until the next done
//   ovf    out  overflow flag
//   unf    out  underflow / flush-to-zero flag
//   inx    out  inexact flag
module fp_seq_unit
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic [1:0]           op,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [EXP_W+MAN_W:0] r,
    output logic                 ovf,
    output logic                 unf,
    output logic                 inx
);

    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int N     = MAN_W + 1;
    localparam int MW    = MAN_W + 4;
    localparam int XW    = EXP_W + 2;
    localparam int CNT_W = $clog2(N + 1);

    localparam logic [FP_MAX_W-1:0] QNAN_FULL = fp_qnan(EXP_W, MAN_W);
    localparam logic [FP_MAX_W-1:0] INF_FULL  = fp_inf(1'b0, EXP_W, MAN_W);
    localparam logic [W-1:0]        QNAN      = QNAN_FULL[W-1:0];
    localparam logic [W-2:0]        INF_MAG   = INF_FULL[W-2:0];
    localparam logic signed [XW-1:0] BIAS     = {3'b000, {(EXP_W-1){1'b1}}};
    localparam logic [EXP_W-1:0]    MAX_SHIFT = EXP_W'(MAN_W + 3);

    logic [3:0]           state;
    logic [W-1:0]         a_q;
    logic [W-1:0]         b_q;
    logic [1:0]           op_q;
    logic [MW-1:0]        big_m;
    logic [MW-1:0]        small_m;
    logic                 big_s;
    logic                 small_s;
    logic [EXP_W-1:0]     diff;
    logic [MW:0]          man;
    logic signed [XW-1:0] exp_q;
    logic                 sign_q;
    logic [2*N-1:0]       prod;
    logic [CNT_W-1:0]     cnt;

    logic                 sa;
    logic                 sb;
    logic                 sb_eff;
    logic                 is_mul;
    logic [EXP_W-1:0]     ea;
    logic [EXP_W-1:0]     eb;
    logic [MAN_W-1:0]     fa;
    logic [MAN_W-1:0]     fb;
    logic signed [XW-1:0] ea_x;
    logic signed [XW-1:0] eb_x;
    logic                 a_zero;
    logic                 b_zero;
    logic                 a_inf;
    logic                 b_inf;
    logic                 a_nan;
    logic                 b_nan;
    logic                 any_special;
    logic [W-1:0]         special_res;

    logic [MW:0]          add_res;
    logic                 add_sign;
    logic [N:0]           mul_sum;
    logic [2*N-1:0]       prod_next;
    logic [MW:0]          mul_man;

    logic [W-1:0]         rnd_res;
    logic                 rnd_ovf;
    logic                 rnd_unf;
    logic                 rnd_inx;

    assign sa     = a_q[W-1];
    assign sb     = b_q[W-1];
    assign ea     = a_q[W-2:MAN_W];
    assign eb     = b_q[W-2:MAN_W];
    assign fa     = a_q[MAN_W-1:0];
    assign fb     = b_q[MAN_W-1:0];
    assign ea_x   = $signed({2'b00, ea});
    assign eb_x   = $signed({2'b00, eb});
    assign is_mul = (op_q == OP_MUL);
    // Subtraction is addition with b's sign flipped.
    assign sb_eff = sb ^ (op_q == OP_SUB);

    // Denormals (exp==0) are treated as zero regardless of fraction.
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (ea == '1) && (fa == '0);
    assign b_inf  = (eb == '1) && (fb == '0);
    assign a_nan  = (ea == '1) && (fa != '0);
    assign b_nan  = (eb == '1) && (fb != '0);
    assign any_special = a_zero | b_zero | a_inf | b_inf | a_nan | b_nan;

    always_comb begin
        special_res = QNAN;
        if (a_nan || b_nan) begin
            special_res = QNAN;
        end else if (is_mul) begin
            if ((a_inf && b_zero) || (a_zero && b_inf))
                special_res = QNAN;
            else if (a_inf || b_inf)
                special_res = {sa ^ sb, INF_MAG};
            else
                special_res = {sa ^ sb, {(W-1){1'b0}}};
        end else begin
            if (a_inf && b_inf)
                special_res = (sa == sb_eff) ? {sa, INF_MAG} : QNAN;
            else if (a_inf)
                special_res = {sa, INF_MAG};
            else if (b_inf)
                special_res = {sb_eff, INF_MAG};
            else if (a_zero && b_zero)
                special_res = {sa & sb_eff, {(W-1){1'b0}}};
            else if (a_zero)
                special_res = {sb_eff, b_q[W-2:0]};
            else
                special_res = a_q;
        end
    end

    // Magnitude add/subtract of the aligned significands. For unlike signs the
    // smaller magnitude is taken from the larger so the result is never negative.
    always_comb begin
        add_res  = '0;
        add_sign = big_s;
        if (big_s == small_s) begin
            add_res = {1'b0, big_m} + {1'b0, small_m};
        end else if (big_m >= small_m) begin
            add_res = {1'b0, big_m - small_m};
        end else begin
            add_res  = {1'b0, small_m - big_m};
            add_sign = small_s;
        end
    end

    // One shift-add step: the multiplier sits in the low half of prod and is
    // consumed LSB first while partial sums enter from the top.
    always_comb begin
        mul_sum   = {1'b0, prod[2*N-1:N]} + (prod[0] ? {1'b0, big_m[MW-1:3]} : {(N+1){1'b0}});
        prod_next = {mul_sum, prod[N-1:1]};
        mul_man   = {prod_next[2*N-1:MAN_W-2], |prod_next[MAN_W-3:0]};
    end

    fp_round #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round (
        .sign   (sign_q),
        .exp_in (exp_q),
        .mant   (man[MW-1:0]),
        .result (rnd_res),
        .ovf    (rnd_ovf),
        .unf    (rnd_unf),
        .inx    (rnd_inx)
    );

    // Main sequencer. Results and done are written on the edge that enters
    // DONE, so done is high during the DONE cycle and start cannot be
    // accepted until the IDLE cycle that follows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            big_m   <= '0;
            small_m <= '0;
            big_s   <= 1'b0;
            small_s <= 1'b0;
            diff    <= '0;
            man     <= '0;
            exp_q   <= '0;
            sign_q  <= 1'b0;
            prod    <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            r       <= '0;
            ovf     <= 1'b0;
            unf     <= 1'b0;
            inx     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        op_q  <= op;
                        busy  <= 1'b1;
                        state <= S_UNPACK;
                    end
                end

                S_UNPACK: begin
                    if (any_special) begin
                        state <= S_SPECIAL;
                    end else if (is_mul) begin
                        big_m  <= {1'b1, fa, 3'b000};
                        prod   <= {{N{1'b0}}, 1'b1, fb};
                        cnt    <= '0;
                        exp_q  <= ea_x + eb_x - BIAS;
                        sign_q <= sa ^ sb;
                        state  <= S_MUL;
                    end else begin
                        // On equal exponents b is the one marked for shifting.
                        if (ea >= eb) begin
                            big_m   <= {1'b1, fa, 3'b000};
                            big_s   <= sa;
                            small_m <= {1'b1, fb, 3'b000};
                            small_s <= sb_eff;
                            diff    <= ea - eb;
                            exp_q   <= ea_x;
                        end else begin
                            big_m   <= {1'b1, fb, 3'b000};
                            big_s   <= sb_eff;
                            small_m <= {1'b1, fa, 3'b000};
                            small_s <= sa;
                            diff    <= eb - ea;
                            exp_q   <= eb_x;
                        end
                        state <= S_ALIGN;
                    end
                end

                S_SPECIAL: begin
                    r     <= special_res;
                    ovf   <= 1'b0;
                    unf   <= 1'b0;
                    inx   <= 1'b0;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_DONE;
                end

                S_ALIGN: begin
                    if (diff == '0) begin
                        state <= S_ADD;
                    end else if (diff > MAX_SHIFT) begin
                        // Everything would be shifted past S: only stickiness survives.
                        small_m <= {{(MW-1){1'b0}}, 1'b1};
                        diff    <= '0;
                        state   <= S_ADD;
                    end else begin
                        small_m <= {1'b0, small_m[MW-1:2], small_m[1] | small_m[0]};
                        diff    <= diff - EXP_W'(1);
                    end
                end

                S_ADD: begin
                    if (add_res == '0) begin
                        r     <= '0;
                        ovf   <= 1'b0;
                        unf   <= 1'b0;
                        inx   <= 1'b0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end else begin
                        man    <= add_res;
                        sign_q <= add_sign;
                        state  <= S_NORM;
                    end
                end

                S_MUL: begin
                    prod <= prod_next;
                    cnt  <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(N - 1)) begin
                        man   <= mul_man;
                        state <= S_NORM;
                    end
                end

                S_NORM: begin
                    if (man[MW]) begin
                        man   <= {1'b0, man[MW:2], man[1] | man[0]};
                        exp_q <= exp_q + XW'(1);
                        state <= S_ROUND;
                    end else if (man[MW-1]) begin
                        state <= S_ROUND;
                    end else begin
                        // Left shift keeps S sticky rather than clearing it.
                        man   <= {man[MW-1:0], man[0]};
                        exp_q <= exp_q - XW'(1);
                    end
                end

                S_ROUND: begin
                    r     <= rnd_res;
                    ovf   <= rnd_ovf;
                    unf   <= rnd_unf;
                    inx   <= rnd_inx;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_DONE;
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_seq_unit.sv
// tb_fp_seq_unit
// Directed-vector bench for fp_seq_unit (EXP_W=8, MAN_W=23). Each vector
// carries a hand-computed result and {ovf, unf, inx} flag triple.
module tb_fp_seq_unit;

    localparam int ADD_LAT = 2 * 23 + 12;
    localparam int MUL_LAT = 2 * 23 + 10;
    localparam int TIMEOUT = 200;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic        start;
    logic        busy;
    logic        done;
    logic [31:0] r;
    logic        ovf;
    logic        unf;
    logic        inx;

    int unsigned assertions_evaluated;
    int unsigned failures;

    fp_seq_unit #(
        .EXP_W (8),
        .MAN_W (23)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
        .op    (op),
        .start (start),
        .busy  (busy),
        .done  (done),
        .r     (r),
        .ovf   (ovf),
        .unf   (unf),
        .inx   (inx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertions_evaluated++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Issue one operation, wait (bounded) for done, then compare result,
    // flags, pulse count and latency. With hold set, start stays high for
    // the whole operation and must not trigger a second one.
    task automatic applyStimulus(input string tag, input logic [31:0] op_a, input logic [31:0] op_b,
                                 input logic [1:0] op_code, input bit hold,
                                 input logic [31:0] exp_r, input logic [2:0] exp_flags,
                                 input int max_cycles);
        int          cycles;
        int          done_count;
        logic [31:0] got_r;
        logic [2:0]  got_flags;
        logic        busy_seen;
        got_r     = '0;
        got_flags = '0;
        @(posedge clk); #1;
        a     = op_a;
        b     = op_b;
        op    = op_code;
        start = 1'b1;
        @(posedge clk); #1;
        busy_seen = busy;
        if (!hold) start = 1'b0;
        cycles     = 0;
        done_count = 0;
        while (!done && cycles < TIMEOUT) begin
            @(posedge clk); #1;
            cycles++;
        end
        start = 1'b0;
        if (done) begin
            done_count = 1;
            got_r      = r;
            got_flags  = {ovf, unf, inx};
        end
        repeat (4) begin
            @(posedge clk); #1;
            if (done) done_count++;
        end
        if (hold) begin
            repeat (60) begin
                @(posedge clk); #1;
                if (done) done_count++;
            end
        end
        checkOutput({tag, "_r"}, {32'd0, got_r}, {32'd0, exp_r});
        checkOutput({tag, "_flags"}, {61'd0, got_flags}, {61'd0, exp_flags});
        checkOutput({tag, "_dones"}, 64'(done_count), 64'd1);
        checkOutput({tag, "_busy"}, {63'd0, busy_seen}, 64'd1);
        checkOutput({tag, "_latency_ok"}, {63'd0, (cycles <= max_cycles)}, 64'd1);
    endtask

    initial begin
        int abort_dones;
        assertions_evaluated = 0;
        failures             = 0;
        rst   = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        op    = 2'b00;
        $display("[TB] fp_seq_unit directed test starting");

        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_r", {32'd0, r}, 64'd0);
        checkOutput("reset_busy", {63'd0, busy}, 64'd0);
        checkOutput("reset_done", {63'd0, done}, 64'd0);
        checkOutput("reset_flags", {61'd0, ovf, unf, inx}, 64'd0);
        rst = 1'b0;

        applyStimulus("add_basic",  32'h3FC00000, 32'h40100000, 2'b00, 1'b0, 32'h40700000, 3'b000, ADD_LAT);
        applyStimulus("sub_zero",   32'h3F800000, 32'h3F800000, 2'b01, 1'b0, 32'h00000000, 3'b000, ADD_LAT);
        applyStimulus("mul_neg",    32'h40400000, 32'hC0000000, 2'b10, 1'b0, 32'hC0C00000, 3'b000, MUL_LAT);
        applyStimulus("add_tie",    32'h3F800000, 32'h33800000, 2'b00, 1'b0, 32'h3F800000, 3'b001, ADD_LAT);
        applyStimulus("add_tie_up", 32'h3F800001, 32'h33800000, 2'b00, 1'b0, 32'h3F800002, 3'b001, ADD_LAT);
        applyStimulus("mul_ovf",    32'h7F7FFFFF, 32'h40000000, 2'b10, 1'b0, 32'h7F800000, 3'b101, MUL_LAT);
        applyStimulus("mul_unf",    32'h00800000, 32'h00800000, 2'b10, 1'b0, 32'h00000000, 3'b011, MUL_LAT);
        applyStimulus("inf_m_inf",  32'h7F800000, 32'hFF800000, 2'b00, 1'b0, 32'h7FC00000, 3'b000, ADD_LAT);
        applyStimulus("zero_x_inf", 32'h00000000, 32'h7F800000, 2'b10, 1'b0, 32'h7FC00000, 3'b000, MUL_LAT);
        applyStimulus("nan_add",    32'h7FC00000, 32'h3F800000, 2'b00, 1'b0, 32'h7FC00000, 3'b000, ADD_LAT);
        applyStimulus("sub_inf",    32'h7F800000, 32'h7F800000, 2'b01, 1'b0, 32'h7FC00000, 3'b000, ADD_LAT);
        applyStimulus("exp_gap200", 32'h7D000000, 32'h19000000, 2'b00, 1'b0, 32'h7D000000, 3'b001, ADD_LAT);
        applyStimulus("sub_cancel", 32'h3F800000, 32'h40100000, 2'b01, 1'b0, 32'hBFA00000, 3'b000, ADD_LAT);
        applyStimulus("add_carry",  32'h3F800000, 32'h3F800000, 2'b00, 1'b0, 32'h40000000, 3'b000, ADD_LAT);
        applyStimulus("mul_carry",  32'h40400000, 32'h40400000, 2'b10, 1'b0, 32'h41100000, 3'b000, MUL_LAT);
        applyStimulus("neg_zeros",  32'h80000000, 32'h80000000, 2'b00, 1'b0, 32'h80000000, 3'b000, ADD_LAT);
        applyStimulus("zero_add",   32'h00000000, 32'h3F800000, 2'b00, 1'b0, 32'h3F800000, 3'b000, ADD_LAT);
        applyStimulus("mul_nzero",  32'h80000000, 32'h3F800000, 2'b10, 1'b0, 32'h80000000, 3'b000, MUL_LAT);
        applyStimulus("held_start", 32'h40400000, 32'hC0000000, 2'b10, 1'b1, 32'hC0C00000, 3'b000, MUL_LAT);
        applyStimulus("op_rsvd",    32'h3FC00000, 32'h40100000, 2'b11, 1'b0, 32'h40700000, 3'b000, ADD_LAT);

        // Abort an add while it is still aligning (exponent gap of 20).
        @(posedge clk); #1;
        a     = 32'h3F800000;
        b     = 32'h35800000;
        op    = 2'b00;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        checkOutput("abort_pre_busy", {63'd0, busy}, 64'd1);
        checkOutput("abort_pre_r", {32'd0, r}, {32'd0, 32'h40700000});
        rst = 1'b1;
        #1;
        checkOutput("abort_busy", {63'd0, busy}, 64'd0);
        checkOutput("abort_done", {63'd0, done}, 64'd0);
        checkOutput("abort_r", {32'd0, r}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        abort_dones = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) abort_dones++;
        end
        checkOutput("abort_no_done", 64'(abort_dones), 64'd0);

        applyStimulus("after_abort", 32'h3FC00000, 32'h40100000, 2'b00, 1'b0, 32'h40700000, 3'b000, ADD_LAT);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions_evaluated, failures);
        $finish;
    end

endmodule
